// File: rtl/prog_loader_pkg.sv
// prog_loader_pkg: shared types and constants for the program loader.
//   state_t   - loader FSM states
//   DATA_W    - instruction word width
//   ADDR_W    - instruction memory address width
//   MAX_WORDS - largest program the instruction memory can hold
package prog_loader_pkg;

    localparam int DATA_W    = 16;
    localparam int ADDR_W    = 9;
    localparam int MAX_WORDS = 1 << ADDR_W;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HDR  = 3'd1,
        ST_LOAD = 3'd2,
        ST_DONE = 3'd3,
        ST_ERR  = 3'd4
    } state_t;

endpackage

// File: rtl/loader_fifo.sv
// loader_fifo: small synchronous FIFO buffering host words ahead of the
// instruction memory write port.
//   clk, rst     - clock, synchronous active-high flush
//   push, wdata  - write a word (ignored while full, even with a same-cycle pop)
//   pop, head    - remove the head word; head is valid whenever !empty
//   full, empty  - derived from the registered occupancy only
module loader_fifo #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] wdata,
    input  logic              pop,
    output logic [DATA_W-1:0] head,
    output logic              full,
    output logic              empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]    cnt_q, cnt_d;
    logic              do_push, do_pop;

    assign full    = (cnt_q == (PTR_W+1)'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign head    = mem_q[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage needs no reset: occupancy decides what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/prog_loader.sv
// prog_loader: takes a length-prefixed word stream from a host, buffers it,
// writes it into instruction memory from address 0 and then starts the CPU.
//   start                      - arm loader (honoured in IDLE, DONE, ERR)
//   in_valid/in_data/in_ready  - host stream: header (length) then words
//   mem_busy                   - memory cannot take a write this cycle
//   mem_wr_en/addr/data        - registered instruction memory write port
//   words_loaded               - words written so far (0..512)
//   load_done, cpu_bgn, err    - completion level, one-cycle CPU start, bad header
module prog_loader #(
    parameter int DATA_W     = prog_loader_pkg::DATA_W,
    parameter int ADDR_W     = prog_loader_pkg::ADDR_W,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    input  logic              mem_busy,
    output logic              mem_wr_en,
    output logic [ADDR_W-1:0] mem_wr_addr,
    output logic [DATA_W-1:0] mem_wr_data,
    output logic [ADDR_W:0]   words_loaded,
    output logic              load_done,
    output logic              cpu_bgn,
    output logic              err
);

    import prog_loader_pkg::*;

    localparam int CNT_W = ADDR_W + 1;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  len_q, len_d;
    logic [CNT_W-1:0]  acc_q, acc_d;        // words accepted from host
    logic [CNT_W-1:0]  wl_q, wl_d;          // words written; low bits are wr_ptr
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              done_q, done_d;
    logic              bgn_q, bgn_d;
    logic              err_q, err_d;

    logic              push, pop, fifo_full, fifo_empty, hdr_ok;
    logic [DATA_W-1:0] fifo_head;

    assign hdr_ok = (in_data != '0) && (in_data <= DATA_W'(MAX_WORDS));

    loader_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (in_data),
        .pop   (pop),
        .head  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        acc_d    = acc_q;
        wl_d     = wl_q;
        wr_en_d  = 1'b0;
        addr_d   = addr_q;
        data_d   = data_q;
        done_d   = done_q;
        bgn_d    = 1'b0;
        err_d    = err_q;
        in_ready = 1'b0;
        push     = 1'b0;
        pop      = 1'b0;
        case (state_q)
            ST_IDLE: if (start) state_d = ST_HDR;
            ST_HDR: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (hdr_ok) begin
                        len_d   = in_data[CNT_W-1:0];
                        acc_d   = '0;
                        wl_d    = '0;
                        state_d = ST_LOAD;
                    end else begin
                        err_d   = 1'b1;
                        state_d = ST_ERR;
                    end
                end
            end
            ST_LOAD: begin
                // Stop accepting once len words are in; nothing past the program.
                in_ready = !fifo_full && (acc_q < len_q);
                push     = in_valid && in_ready;
                if (push) acc_d = acc_q + 1'b1;
                if (!fifo_empty && !mem_busy) begin
                    pop     = 1'b1;
                    wr_en_d = 1'b1;
                    addr_d  = wl_q[ADDR_W-1:0];
                    data_d  = fifo_head;
                    wl_d    = wl_q + 1'b1;
                end
                // wl_q reaches len in the cycle the final write is on the port,
                // so DONE follows that write cycle by one edge.
                if (wl_q == len_q) begin
                    done_d  = 1'b1;
                    bgn_d   = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: if (start) begin
                done_d  = 1'b0;
                acc_d   = '0;
                wl_d    = '0;
                state_d = ST_HDR;
            end
            ST_ERR: if (start) begin
                err_d   = 1'b0;
                acc_d   = '0;
                wl_d    = '0;
                state_d = ST_HDR;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            len_q   <= '0;
            acc_q   <= '0;
            wl_q    <= '0;
            wr_en_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
            bgn_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            acc_q   <= acc_d;
            wl_q    <= wl_d;
            wr_en_q <= wr_en_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            done_q  <= done_d;
            bgn_q   <= bgn_d;
            err_q   <= err_d;
        end
    end

    assign mem_wr_en    = wr_en_q;
    assign mem_wr_addr  = addr_q;
    assign mem_wr_data  = data_q;
    assign words_loaded = wl_q;
    assign load_done    = done_q;
    assign cpu_bgn      = bgn_q;
    assign err          = err_q;

endmodule

// File: tb/tb_prog_loader.sv
module tb_prog_loader;

    logic        clk = 1'b0;
    logic        rst, start, in_valid, in_ready, mem_busy;
    logic        mem_wr_en, load_done, cpu_bgn, err;
    logic [15:0] in_data, mem_wr_data;
    logic [8:0]  mem_wr_addr;
    logic [9:0]  words_loaded;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int bgn_cnt = 0;

    // write log captured away from the active edge
    logic [8:0]  wa[$];
    logic [15:0] wd[$];
    int          wt[$];

    prog_loader dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .mem_busy     (mem_busy),
        .mem_wr_en    (mem_wr_en),
        .mem_wr_addr  (mem_wr_addr),
        .mem_wr_data  (mem_wr_data),
        .words_loaded (words_loaded),
        .load_done    (load_done),
        .cpu_bgn      (cpu_bgn),
        .err          (err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;
    always @(negedge clk) begin
        if (mem_wr_en) begin
            wa.push_back(mem_wr_addr);
            wd.push_back(mem_wr_data);
            wt.push_back(cyc);
        end
        if (cpu_bgn) bgn_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        wa.delete();
        wd.delete();
        wt.delete();
        bgn_cnt = 0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_word(input logic [15:0] w);
        bit ok = 0;
        in_valid = 1'b1;
        in_data  = w;
        for (int i = 0; i < 60 && !ok; i++) begin
            ok = in_ready;
            tick();
        end
        in_valid = 1'b0;
        if (!ok) begin
            total++; bad++;
            $display("FAIL send_word: word %h never accepted, required acceptance", w);
        end
    endtask

    task automatic wait_done(input int lim);
        bit ok = 0;
        for (int i = 0; i < lim && !ok; i++) begin
            if (load_done) ok = 1;
            else tick();
        end
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL wait_done: load_done=0 after %0d cycles, required 1", lim);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0; mem_busy = 1'b0;
        repeat (3) tick();
        total += 8;
        if (in_ready !== 1'b0)     begin bad++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
        if (mem_wr_en !== 1'b0)    begin bad++; $display("FAIL rst_wr_en: got %b want 0", mem_wr_en); end
        if (mem_wr_addr !== 9'd0)  begin bad++; $display("FAIL rst_addr: got %0d want 0", mem_wr_addr); end
        if (mem_wr_data !== 16'd0) begin bad++; $display("FAIL rst_data: got %h want 0", mem_wr_data); end
        if (words_loaded !== 10'd0) begin bad++; $display("FAIL rst_words: got %0d want 0", words_loaded); end
        if (load_done !== 1'b0)    begin bad++; $display("FAIL rst_done: got %b want 0", load_done); end
        if (cpu_bgn !== 1'b0)      begin bad++; $display("FAIL rst_bgn: got %b want 0", cpu_bgn); end
        if (err !== 1'b0)          begin bad++; $display("FAIL rst_err: got %b want 0", err); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        logic [15:0] exp_d [3];
        exp_d[0] = 16'hA001; exp_d[1] = 16'hA002; exp_d[2] = 16'hA003;
        clear_log();
        pulse_start();
        send_word(16'd3);
        for (int i = 0; i < 3; i++) send_word(exp_d[i]);
        wait_done(20);
        total += 3;
        if (cpu_bgn !== 1'b1) begin bad++; $display("FAIL basic_bgn_with_done: cpu_bgn=%b want 1", cpu_bgn); end
        if (words_loaded !== 10'd3) begin bad++; $display("FAIL basic_words: got %0d want 3", words_loaded); end
        if (wa.size() != 3) begin bad++; $display("FAIL basic_nwrites: got %0d want 3", wa.size()); end
        for (int i = 0; i < 3 && i < wa.size(); i++) begin
            total += 2;
            if (wa[i] !== 9'(i)) begin bad++; $display("FAIL basic_addr%0d: got %0d want %0d", i, wa[i], i); end
            if (wd[i] !== exp_d[i]) begin bad++; $display("FAIL basic_data%0d: got %h want %h", i, wd[i], exp_d[i]); end
        end
        if (wt.size() == 3) begin
            total++;
            if (wt[1] != wt[0] + 1 || wt[2] != wt[1] + 1) begin
                bad++; $display("FAIL basic_consecutive: cycles %0d %0d %0d want consecutive", wt[0], wt[1], wt[2]);
            end
        end
        repeat (3) tick();
        total += 3;
        if (cpu_bgn !== 1'b0) begin bad++; $display("FAIL basic_bgn_drop: got %b want 0", cpu_bgn); end
        if (bgn_cnt != 1) begin bad++; $display("FAIL basic_bgn_pulses: got %0d want 1", bgn_cnt); end
        if (load_done !== 1'b1) begin bad++; $display("FAIL basic_done_level: got %b want 1", load_done); end
    endtask

    task automatic test_start_in_done();
        pulse_start();
        total += 3;
        if (load_done !== 1'b0) begin bad++; $display("FAIL done_restart_done: got %b want 0", load_done); end
        if (words_loaded !== 10'd0) begin bad++; $display("FAIL done_restart_words: got %0d want 0", words_loaded); end
        if (in_ready !== 1'b1) begin bad++; $display("FAIL done_restart_hdr_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_illegal_hdr();
        logic [15:0] hdrs [2];
        hdrs[0] = 16'd0; hdrs[1] = 16'd513;
        for (int h = 0; h < 2; h++) begin
            clear_log();
            send_word(hdrs[h]);
            total += 2;
            if (err !== 1'b1) begin bad++; $display("FAIL illegal_err_%0d: got %b want 1", hdrs[h], err); end
            if (in_ready !== 1'b0) begin bad++; $display("FAIL illegal_ready_%0d: got %b want 0", hdrs[h], in_ready); end
            in_valid = 1'b1; in_data = 16'h1234;
            repeat (4) tick();
            in_valid = 1'b0;
            total += 2;
            if (wa.size() != 0) begin bad++; $display("FAIL illegal_writes_%0d: got %0d want 0", hdrs[h], wa.size()); end
            if (err !== 1'b1) begin bad++; $display("FAIL illegal_err_hold_%0d: got %b want 1", hdrs[h], err); end
            pulse_start();
            total++;
            if (err !== 1'b0) begin bad++; $display("FAIL illegal_clear_%0d: got %b want 0", hdrs[h], err); end
        end
    endtask

    task automatic test_backpressure();
        int acc = 0;
        bit hs;
        clear_log();
        send_word(16'd8);
        mem_busy = 1'b1;
        for (int c = 0; c < 10; c++) begin
            in_valid = 1'b1;
            in_data  = 16'hB000 + 16'(acc);
            hs = in_ready;
            tick();
            if (hs) acc++;
        end
        in_valid = 1'b0;
        total += 3;
        if (acc != 4) begin bad++; $display("FAIL bp_accepted: got %0d want 4", acc); end
        if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_ready_full: got %b want 0", in_ready); end
        if (wa.size() != 0) begin bad++; $display("FAIL bp_no_writes: got %0d want 0", wa.size()); end
        mem_busy = 1'b0;
        for (int i = acc; i < 8; i++) send_word(16'hB000 + 16'(i));
        wait_done(30);
        total += 2;
        if (wa.size() != 8) begin bad++; $display("FAIL bp_nwrites: got %0d want 8", wa.size()); end
        if (words_loaded !== 10'd8) begin bad++; $display("FAIL bp_words: got %0d want 8", words_loaded); end
        for (int i = 0; i < 8 && i < wa.size(); i++) begin
            total += 2;
            if (wa[i] !== 9'(i)) begin bad++; $display("FAIL bp_addr%0d: got %0d want %0d", i, wa[i], i); end
            if (wd[i] !== 16'hB000 + 16'(i)) begin bad++; $display("FAIL bp_data%0d: got %h want %h", i, wd[i], 16'hB000 + 16'(i)); end
        end
    endtask

    task automatic test_full_program();
        pulse_start();
        clear_log();
        send_word(16'd512);
        for (int i = 0; i < 512; i++) send_word(16'(i) ^ 16'h5A5A);
        in_valid = 1'b1; in_data = 16'hFFFF;
        for (int c = 0; c < 4; c++) begin
            total++;
            if (in_ready !== 1'b0) begin bad++; $display("FAIL full_513th_ready: got %b want 0", in_ready); end
            tick();
        end
        wait_done(20);
        in_valid = 1'b0;
        tick();
        total += 3;
        if (wa.size() != 512) begin bad++; $display("FAIL full_nwrites: got %0d want 512", wa.size()); end
        if (words_loaded !== 10'd512) begin bad++; $display("FAIL full_words: got %0d want 512", words_loaded); end
        if (bgn_cnt != 1) begin bad++; $display("FAIL full_bgn: got %0d want 1", bgn_cnt); end
        for (int i = 0; i < 512 && i < wa.size(); i++) begin
            total += 2;
            if (wa[i] !== 9'(i)) begin bad++; $display("FAIL full_addr%0d: got %0d want %0d", i, wa[i], i); end
            if (wd[i] !== (16'(i) ^ 16'h5A5A)) begin bad++; $display("FAIL full_data%0d: got %h want %h", i, wd[i], 16'(i) ^ 16'h5A5A); end
        end
    endtask

    task automatic test_reset_mid_load();
        pulse_start();
        clear_log();
        send_word(16'd5);
        send_word(16'hC001);
        send_word(16'hC002);
        send_word(16'hC003);
        for (int i = 0; i < 10 && wa.size() < 2; i++) tick();
        rst = 1'b1;
        tick();
        total += 8;
        if (in_ready !== 1'b0)     begin bad++; $display("FAIL mid_rst_in_ready: got %b want 0", in_ready); end
        if (mem_wr_en !== 1'b0)    begin bad++; $display("FAIL mid_rst_wr_en: got %b want 0", mem_wr_en); end
        if (mem_wr_addr !== 9'd0)  begin bad++; $display("FAIL mid_rst_addr: got %0d want 0", mem_wr_addr); end
        if (mem_wr_data !== 16'd0) begin bad++; $display("FAIL mid_rst_data: got %h want 0", mem_wr_data); end
        if (words_loaded !== 10'd0) begin bad++; $display("FAIL mid_rst_words: got %0d want 0", words_loaded); end
        if (load_done !== 1'b0)    begin bad++; $display("FAIL mid_rst_done: got %b want 0", load_done); end
        if (cpu_bgn !== 1'b0)      begin bad++; $display("FAIL mid_rst_bgn: got %b want 0", cpu_bgn); end
        if (err !== 1'b0)          begin bad++; $display("FAIL mid_rst_err: got %b want 0", err); end
        rst = 1'b0;
        tick();
        clear_log();
        pulse_start();
        send_word(16'd2);
        send_word(16'hD001);
        send_word(16'hD002);
        wait_done(20);
        total += 2;
        if (wa.size() != 2) begin bad++; $display("FAIL mid_reload_nwrites: got %0d want 2", wa.size()); end
        if (words_loaded !== 10'd2) begin bad++; $display("FAIL mid_reload_words: got %0d want 2", words_loaded); end
        if (wa.size() == 2) begin
            total += 4;
            if (wa[0] !== 9'd0) begin bad++; $display("FAIL mid_reload_addr0: got %0d want 0", wa[0]); end
            if (wd[0] !== 16'hD001) begin bad++; $display("FAIL mid_reload_data0: got %h want d001", wd[0]); end
            if (wa[1] !== 9'd1) begin bad++; $display("FAIL mid_reload_addr1: got %0d want 1", wa[1]); end
            if (wd[1] !== 16'hD002) begin bad++; $display("FAIL mid_reload_data1: got %h want d002", wd[1]); end
        end
    endtask

    task automatic test_start_in_load();
        pulse_start();
        clear_log();
        send_word(16'd4);
        send_word(16'hE001);
        send_word(16'hE002);
        start = 1'b1;
        send_word(16'hE003);
        start = 1'b0;
        total++;
        if (load_done !== 1'b0 || in_ready !== 1'b1) begin
            bad++; $display("FAIL load_start_ignored: done=%b ready=%b want done=0 ready=1", load_done, in_ready);
        end
        send_word(16'hE004);
        wait_done(20);
        total += 2;
        if (wa.size() != 4) begin bad++; $display("FAIL load_start_nwrites: got %0d want 4", wa.size()); end
        if (words_loaded !== 10'd4) begin bad++; $display("FAIL load_start_words: got %0d want 4", words_loaded); end
        for (int i = 0; i < 4 && i < wa.size(); i++) begin
            total += 2;
            if (wa[i] !== 9'(i)) begin bad++; $display("FAIL load_start_addr%0d: got %0d want %0d", i, wa[i], i); end
            if (wd[i] !== 16'hE001 + 16'(i)) begin bad++; $display("FAIL load_start_data%0d: got %h want %h", i, wd[i], 16'hE001 + 16'(i)); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_start_in_done();
        test_illegal_hdr();
        test_backpressure();
        test_full_program();
        test_reset_mid_load();
        test_start_in_load();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/prog_loader.md
# prog_loader

- Program loader that sits directly upstream of the CPU block's instruction memory.
- Accepts a length-prefixed stream of 16-bit instruction words from a host over a valid/ready handshake and buffers them in a small FIFO.
- Writes the words sequentially into instruction memory from address 0.
- On completion, raises a done level and issues a one-cycle `cpu_bgn` pulse that starts the CPU.

## Interface
Parameters:
- `DATA_W`, 16, instruction word width
- `ADDR_W`, 9, instruction memory address width (512 words)
- `FIFO_DEPTH`, 4, input buffer depth (power of two, ≥2)

Ports:
- `clk`  in  1  single clock; all state on rising edge
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  arm loader; sampled only in IDLE, DONE, ERR
- `in_valid`  in  1  host word valid
- `in_data`  in  16  header (length) or instruction word
- `in_ready`  out  1  loader can accept word
- `mem_busy`  in  1  instruction memory cannot take a write this cycle
- `mem_wr_en`  out  1  write strobe to instruction memory
- `mem_wr_addr`  out  9  write address
- `mem_wr_data`  out  16  write data
- `words_loaded`  out  10  count of words written (0..512)
- `load_done`  out  1  level, program fully written
- `cpu_bgn`  out  1  one-cycle start pulse to the CPU
- `err`  out  1  level, illegal header

## Operation
- **Transfer:** a handshake occurs when `in_valid && in_ready` at a rising edge.
- **States:** IDLE, HDR, LOAD, DONE, ERR.
- **IDLE**
  - `in_ready=0`.
  - `start` → HDR.
- **HDR**
  - `in_ready=1`.
  - On handshake, `len = in_data`.
  - If `1 ≤ len ≤ 512`: latch `len`, clear the counters, go to LOAD.
  - Otherwise: go to ERR.
- **LOAD, accept side**
  - `in_ready = !fifo_full && (accepted < len)`.
  - `fifo_full` is taken from the registered occupancy only; no push is allowed while full, even when a pop happens in the same cycle.
  - Words beyond `len` are never accepted.
- **LOAD, write side**
  - When the FIFO is non-empty and `!mem_busy`: pop the head, drive `mem_wr_en=1`, `mem_wr_addr=wr_ptr`, `mem_wr_data=head`, then increment `wr_ptr` and `words_loaded`.
  - When `words_loaded` reaches `len`, go to DONE on the next edge.
- **Address range:** `wr_ptr` never exceeds 511; with `len=512` the last write is to 511 and there is no wrap.
- **DONE**
  - `load_done=1`.
  - `cpu_bgn=1` only in the first DONE cycle.
  - `words_loaded` holds.
  - `start` → HDR: clears `load_done` and the counters, reloads from address 0.
- **ERR**
  - `err=1`, `in_ready=0`, no memory writes.
  - `start` → HDR and clears `err`.
- **Ignored `start`:** `start` in HDR or LOAD is ignored.
- **Reset:** `rst` at any time, including mid-load, flushes the FIFO, clears all counters and returns to IDLE. Memory contents already written are not undone.

## Timing
- **Reset values:** `in_ready=0`, `mem_wr_en=0`, `mem_wr_addr=0`, `mem_wr_data=0`, `words_loaded=0`, `load_done=0`, `cpu_bgn=0`, `err=0`.
- **Registered outputs:** all outputs are registered except `in_ready`, which is combinational from state and registered counters only.
- **Latency:** a word accepted at edge t is written no earlier than the cycle after t, provided `mem_busy=0`.
- **Throughput:** 1 word/cycle when `mem_busy` stays low.
- **`mem_busy` rule:** `mem_busy` is sampled in the same cycle as the write decision. If high, the FIFO head is held and `mem_wr_en=0`.
- **Completion:** DONE is entered one edge after the final write cycle. `cpu_bgn` is high for exactly that one cycle and `load_done` rises with it.
- **ERR entry:** ERR is entered on the edge after the header handshake.

## Structure
- **Package `prog_loader_pkg`:**
  - state enum (IDLE, HDR, LOAD, DONE, ERR)
  - `DATA_W`, `ADDR_W`
  - `MAX_WORDS = 512`
- **Sub-module `loader_fifo`:**
  - synchronous FIFO, `DATA_W` × `FIFO_DEPTH`
  - push/pop, `full`/`empty`, registered occupancy
  - synchronous flush on `rst`
- **Top level:** FSM plus accept/write counters.

## Test plan
- **Basic load:** reset; `start`; header 3; words A001, A002, A003 back-to-back; `mem_busy=0`.
  - Writes occur in three consecutive cycles: addr 0/A001, 1/A002, 2/A003.
  - Then `cpu_bgn` is a single pulse, `load_done=1`, `words_loaded=3`.
- **Illegal headers:** header 0 → `err=1`, `in_ready=0`, no `mem_wr_en`. Repeat with header 513 → same response. A following `start` clears `err`.
- **Backpressure:** header 8; `mem_busy=1` for 10 cycles while the host streams.
  - `in_ready` drops after 4 accepted words and no writes occur during busy.
  - After release, addr 0..7 hold words in order; no loss or duplication.
- **Full program:** header 512 with 512 words.
  - Last write is to addr 511, `words_loaded=512`.
  - A 513th valid word is not accepted.
- **Reset mid-load:** header 5; `rst` asserted after 2 writes.
  - All outputs are at reset values the next cycle.
  - A new load of 2 words writes addr 0 and 1, `words_loaded=2`.
- **`start` handling:** `start` pulsed during LOAD has no effect. `start` in DONE returns to HDR with `load_done=0` and `words_loaded=0`.
